operand_fetch: RTL and testbench

Operand fetch stage sitting directly upstream of `register_file`: accepts one decoded instruction (two source selects plus an opaque tag), reads both source operands through the register file's single read port in sequence, and presents them to execute with a valid/ready handshake. It snoops the register file write port so that a read blocked by a write cycle is retried, and a same-cycle write to the register being captured is bypassed.

---
 rtl/operand_fetch.sv | 135 +++++++++++++
 tb/tb_operand_fetch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads two source operands through the register
// file's single read port and hands them to execute via valid/ready.
module operand_fetch #(
   parameter int DATA_W = 33,
   parameter int SEL_W  = 6,
   parameter int TAG_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [SEL_W-1:0]  in_rs,
   input  logic [SEL_W-1:0]  in_rt,
   input  logic [TAG_W-1:0]  in_tag,
   output logic [SEL_W-1:0]  rf_rsel,
   input  logic [DATA_W-1:0] rf_rdata,
   input  logic              rf_wen,
   input  logic [SEL_W-1:0]  rf_wsel,
   input  logic [DATA_W-1:0] rf_wdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [TAG_W-1:0]  out_tag
);

   typedef enum logic [2:0] {
      IDLE,
      REQ_A,
      REQ_B,
      CAP_B,
      OUT
   } state_t;

   state_t state, state_nx;

   logic [SEL_W-1:0]  rs_q, rt_q;
   logic [TAG_W-1:0]  tag_q, otag_q;
   logic [DATA_W-1:0] a_q, b_q, oa_q;
   logic              a_done;
   logic [DATA_W-1:0] a_cap, b_cap;
   logic              accept, load_a, load_out;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      rf_rsel   = '0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = REQ_A;
         end
         REQ_A: begin
            rf_rsel = rs_q;
            if (!rf_wen) state_nx = REQ_B;
         end
         REQ_B: begin
            rf_rsel = rt_q;
            if (!rf_wen) state_nx = CAP_B;
         end
         CAP_B: begin
            rf_rsel  = rt_q;
            state_nx = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Selector 0 reads as zero; a same-cycle write to the selector wins.
   always_comb begin
      a_cap = rf_rdata;
      b_cap = rf_rdata;
      if (rs_q == '0)
         a_cap = '0;
      else if (rf_wen && rf_wsel == rs_q)
         a_cap = rf_wdata;
      if (rt_q == '0)
         b_cap = '0;
      else if (rf_wen && rf_wsel == rt_q)
         b_cap = rf_wdata;
   end

   assign accept   = (state == IDLE) && in_valid;
   assign load_a   = (state == REQ_B) && !a_done;
   assign load_out = (state == CAP_B);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rs_q   <= '0;
         rt_q   <= '0;
         tag_q  <= '0;
         a_q    <= '0;
         a_done <= 1'b0;
      end else begin
         if (accept) begin
            rs_q   <= in_rs;
            rt_q   <= in_rt;
            tag_q  <= in_tag;
            a_done <= 1'b0;
         end
         if (load_a) begin
            a_q    <= a_cap;
            a_done <= 1'b1;
         end
      end
   end

   // Output registers load only on entry to OUT so they never glitch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         oa_q   <= '0;
         b_q    <= '0;
         otag_q <= '0;
      end else if (load_out) begin
         oa_q   <= a_q;
         b_q    <= b_cap;
         otag_q <= tag_q;
      end
   end

   assign out_a   = oa_q;
   assign out_b   = b_q;
   assign out_tag = otag_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small register file model
// that answers reads one cycle late and skips reads on write cycles.
module tb_operand_fetch;

   localparam int DATA_W = 33;
   localparam int SEL_W  = 6;
   localparam int TAG_W  = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [SEL_W-1:0]  in_rs = '0;
   logic [SEL_W-1:0]  in_rt = '0;
   logic [TAG_W-1:0]  in_tag = '0;
   logic [SEL_W-1:0]  rf_rsel;
   logic [DATA_W-1:0] rf_rdata = '0;
   logic              rf_wen = 1'b0;
   logic [SEL_W-1:0]  rf_wsel = '0;
   logic [DATA_W-1:0] rf_wdata = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [DATA_W-1:0] out_a, out_b;
   logic [TAG_W-1:0]  out_tag;

   logic [DATA_W-1:0] regs [64];

   int checks = 0;
   int fails  = 0;

   operand_fetch #(
      .DATA_W(DATA_W),
      .SEL_W (SEL_W),
      .TAG_W (TAG_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_rs    (in_rs),
      .in_rt    (in_rt),
      .in_tag   (in_tag),
      .rf_rsel  (rf_rsel),
      .rf_rdata (rf_rdata),
      .rf_wen   (rf_wen),
      .rf_wsel  (rf_wsel),
      .rf_wdata (rf_wdata),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_a    (out_a),
      .out_b    (out_b),
      .out_tag  (out_tag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rf_wen) regs[rf_wsel] = rf_wdata;
      else        rf_rdata <= regs[rf_rsel];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one instruction and return with the accept edge taken.
   task automatic issue(input logic [SEL_W-1:0] rs,
                        input logic [SEL_W-1:0] rt,
                        input logic [TAG_W-1:0] tag);
      in_valid = 1'b1;
      in_rs    = rs;
      in_rt    = rt;
      in_tag   = tag;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(inout int n);
      while (!out_valid && n < 30) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_a !== '0 || out_b !== '0 || out_tag !== '0) begin
         fails++;
         $display("FAIL reset_out: valid=%b a=%h b=%h tag=%h expected all 0",
                  out_valid, out_a, out_b, out_tag);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1 || rf_rsel !== '0) begin
         fails++;
         $display("FAIL reset_idle: in_ready=%b rsel=%0d expected 1/0",
                  in_ready, rf_rsel);
      end
   endtask

   task automatic test_basic();
      int n;
      issue(6'd4, 6'd5, 32'hA5);
      n = 1;
      checks++;
      if (rf_rsel !== 6'd4 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL basic_req_a: rsel=%0d in_ready=%b expected 4/0",
                  rf_rsel, in_ready);
      end
      wait_valid(n);
      checks++;
      if (n !== 4) begin
         fails++;
         $display("FAIL basic_latency: got %0d expected 4", n);
      end
      checks++;
      if (out_a !== 33'h11 || out_b !== 33'h22 || out_tag !== 32'hA5) begin
         fails++;
         $display("FAIL basic_data: a=%h b=%h tag=%h expected 11/22/a5",
                  out_a, out_b, out_tag);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL basic_handshake: valid=%b in_ready=%b expected 0/1",
                  out_valid, in_ready);
      end
   endtask

   task automatic test_mid_reset();
      int n;
      issue(6'd4, 6'd5, 32'h1234);
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_a !== '0 || out_b !== '0 || out_tag !== '0) begin
         fails++;
         $display("FAIL midreset_out: valid=%b a=%h b=%h tag=%h expected 0",
                  out_valid, out_a, out_b, out_tag);
      end
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL midreset_idle: in_ready=%b valid=%b expected 1/0",
                  in_ready, out_valid);
      end
      issue(6'd5, 6'd4, 32'h3C);
      n = 1;
      wait_valid(n);
      checks++;
      if (n !== 4 || out_a !== 33'h22 || out_b !== 33'h11 || out_tag !== 32'h3C) begin
         fails++;
         $display("FAIL midreset_new: lat=%0d a=%h b=%h tag=%h expected 4/22/11/3c",
                  n, out_a, out_b, out_tag);
      end
      tick();
   endtask

   task automatic test_stall_a();
      int n;
      issue(6'd4, 6'd5, 32'hA5);
      rf_wen   = 1'b1;
      rf_wsel  = 6'd9;
      rf_wdata = 33'h99;
      tick();
      checks++;
      if (rf_rsel !== 6'd4) begin
         fails++;
         $display("FAIL stall_a_rsel1: rsel=%0d expected 4", rf_rsel);
      end
      tick();
      checks++;
      if (rf_rsel !== 6'd4) begin
         fails++;
         $display("FAIL stall_a_rsel2: rsel=%0d expected 4", rf_rsel);
      end
      rf_wen = 1'b0;
      n = 3;
      wait_valid(n);
      checks++;
      if (n !== 6 || out_a !== 33'h11 || out_b !== 33'h22 || out_tag !== 32'hA5) begin
         fails++;
         $display("FAIL stall_a: lat=%0d a=%h b=%h tag=%h expected 6/11/22/a5",
                  n, out_a, out_b, out_tag);
      end
      tick();
   endtask

   task automatic test_bypass_b();
      int n;
      issue(6'd4, 6'd5, 32'h5A);
      tick();
      rf_wen   = 1'b1;
      rf_wsel  = 6'd4;
      rf_wdata = 33'h77;
      tick();
      rf_wen = 1'b0;
      checks++;
      if (rf_rsel !== 6'd5) begin
         fails++;
         $display("FAIL bypass_retry_rsel: rsel=%0d expected 5", rf_rsel);
      end
      n = 3;
      wait_valid(n);
      checks++;
      if (n !== 5 || out_a !== 33'h77 || out_b !== 33'h22 || out_tag !== 32'h5A) begin
         fails++;
         $display("FAIL bypass_b: lat=%0d a=%h b=%h tag=%h expected 5/77/22/5a",
                  n, out_a, out_b, out_tag);
      end
      tick();
      regs[4] = 33'h11;
   endtask

   task automatic test_zero();
      int n;
      issue(6'd0, 6'd0, 32'hFFFF_0000);
      n = 1;
      wait_valid(n);
      checks++;
      if (n !== 4 || out_a !== '0 || out_b !== '0 || out_tag !== 32'hFFFF_0000) begin
         fails++;
         $display("FAIL zero_sel: lat=%0d a=%h b=%h tag=%h expected 4/0/0/ffff0000",
                  n, out_a, out_b, out_tag);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int n;
      int bad;
      out_ready = 1'b0;
      issue(6'd5, 6'd5, 32'hBEEF);
      n = 1;
      wait_valid(n);
      in_valid = 1'b1;
      in_rs    = 6'd4;
      in_rt    = 6'd4;
      in_tag   = 32'h1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_a !== 33'h22 ||
             out_b !== 33'h22 || out_tag !== 32'hBEEF)
            bad++;
      end
      checks++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL backpressure_hold: %0d unstable cycles expected 0", bad);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_tag !== 32'hBEEF) begin
         fails++;
         $display("FAIL backpressure_release: valid=%b in_ready=%b tag=%h expected 0/1/beef",
                  out_valid, in_ready, out_tag);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      in_valid = 1'b1;
      in_rs    = 6'd4;
      in_rt    = 6'd5;
      in_tag   = 32'h77;
      tick();
      n = 1;
      wait_valid(n);
      n = 0;
      tick();
      n++;
      wait_valid(n);
      in_valid = 1'b0;
      checks++;
      if (n !== 5) begin
         fails++;
         $display("FAIL back_to_back_period: got %0d expected 5", n);
      end
      tick();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) regs[i] = 33'(i) * 33'h101;
      regs[0] = 33'h1_FFFF_FFFF;
      regs[4] = 33'h11;
      regs[5] = 33'h22;
      test_reset();
      test_basic();
      test_mid_reset();
      test_stall_a();
      test_bypass_b();
      test_zero();
      test_backpressure();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
